// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 16-bit memory.
// One transaction at a time: IDLE (grant) -> ACCESS (memory cycle) -> RESP (ack).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 2048
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    // Highest legal high-byte address: the low byte must still be inside memory.
    localparam logic [ADDR_WIDTH:0] LAST_OK = (ADDR_WIDTH+1)'(MEM_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Everything latched at grant time; requesters may change inputs afterwards.
    typedef struct packed {
        logic                  id;
        logic                  we;
        logic                  ok;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } txn_t;

    state_t                state_q, state_d;
    txn_t                  txn_q;
    logic                  ptr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            req_v;
    logic                  grant;
    logic                  win;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_ok;

    assign req_v = {req1, req0};

    // Winner selection: pointer breaks ties, a lone requester always wins.
    always_comb begin
        win = (req_v == 2'b11) ? ptr_q : req_v[1];
    end

    assign sel_we    = win ? we1    : we0;
    assign sel_addr  = win ? addr1  : addr0;
    assign sel_wdata = win ? wdata1 : wdata0;
    assign sel_ok    = ({1'b0, sel_addr} <= LAST_OK);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and FSM-decoded outputs.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        mem_wr_en = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (|req_v) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_wr_en = txn_q.we & txn_q.ok;
                state_d   = RESP;
            end
            RESP: begin
                ack0    = ~txn_q.id;
                ack1    = txn_q.id;
                err0    = ~txn_q.id & ~txn_q.ok;
                err1    = txn_q.id & ~txn_q.ok;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction latch, priority pointer and read-data capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            txn_q   <= '0;
            ptr_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (grant) begin
                txn_q <= '{id: win, we: sel_we, ok: sel_ok, addr: sel_addr, wdata: sel_wdata};
                ptr_q <= ~win;
            end
            if (state_q == ACCESS)
                rdata_q <= (!txn_q.we && txn_q.ok) ? mem_data_out : '0;
        end
    end

    // Memory address/data come straight from the latch, so they hold between accesses.
    assign mem_address = txn_q.addr;
    assign mem_data_in = txn_q.wdata;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a big-endian byte memory model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy, mem_wr_en;
    logic [15:0] rdata, mem_address, mem_data_in, mem_data_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:2047];

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .busy(busy),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    // Memory model: combinational big-endian read, write on the clock edge.
    always_comb begin
        mem_data_out = 16'h0000;
        if (int'(mem_address) <= 2046)
            mem_data_out = {mem[int'(mem_address)], mem[int'(mem_address) + 1]};
    end

    always @(posedge clock) begin
        if (mem_wr_en && int'(mem_address) <= 2046) begin
            mem[int'(mem_address)]     <= mem_data_in[15:8];
            mem[int'(mem_address) + 1] <= mem_data_in[7:0];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        n_cmp++; if ({ack0, ack1, err0, err1} !== 4'b0) begin n_bad++; $display("FAIL reset_ack_err: got %b want 0000", {ack0, ack1, err0, err1}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
        n_cmp++; if ({mem_address, mem_data_in} !== 32'h0) begin n_bad++; $display("FAIL reset_mem_bus: got %h want 00000000", {mem_address, mem_data_in}); end
        reset = 0;
        tick();
    endtask

    // Read 0x0008 by req0; req dropped mid-transaction must not disturb the ack.
    task automatic test_read();
        req0 = 1; we0 = 0; addr0 = 16'h0008;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b want 1", busy); end
        n_cmp++; if (mem_address !== 16'h0008) begin n_bad++; $display("FAIL read_addr: got %h want 0008", mem_address); end
        n_cmp++; if ({mem_wr_en, ack0} !== 2'b00) begin n_bad++; $display("FAIL read_access: got %b want 00", {mem_wr_en, ack0}); end
        req0 = 0;
        tick();
        n_cmp++; if ({ack0, ack1, err0} !== 3'b100) begin n_bad++; $display("FAIL read_ack: got %b want 100", {ack0, ack1, err0}); end
        n_cmp++; if (rdata !== 16'h0010) begin n_bad++; $display("FAIL read_rdata: got %h want 0010", rdata); end
        tick();
        n_cmp++; if ({ack0, busy} !== 2'b00) begin n_bad++; $display("FAIL read_after: got %b want 00", {ack0, busy}); end
    endtask

    // Write 0xABCD to the last legal address by req1, then read it back by req0.
    task automatic test_write_read();
        int wr_cycles = 0;
        req1 = 1; we1 = 1; addr1 = 16'h07FE; wdata1 = 16'hABCD;
        tick();
        if (mem_wr_en) wr_cycles++;
        n_cmp++; if (mem_data_in !== 16'hABCD) begin n_bad++; $display("FAIL wr_data_in: got %h want abcd", mem_data_in); end
        tick();
        if (mem_wr_en) wr_cycles++;
        n_cmp++; if ({ack1, err1, ack0} !== 3'b100) begin n_bad++; $display("FAIL wr_ack: got %b want 100", {ack1, err1, ack0}); end
        n_cmp++; if (rdata !== 16'h0) begin n_bad++; $display("FAIL wr_rdata: got %h want 0000", rdata); end
        req1 = 0; we1 = 0;
        tick();
        if (mem_wr_en) wr_cycles++;
        n_cmp++; if (wr_cycles !== 1) begin n_bad++; $display("FAIL wr_en_cycles: got %0d want 1", wr_cycles); end
        n_cmp++; if ({mem[2046], mem[2047]} !== 16'hABCD) begin n_bad++; $display("FAIL wr_mem: got %h want abcd", {mem[2046], mem[2047]}); end
        n_cmp++; if (mem_address !== 16'h07FE) begin n_bad++; $display("FAIL wr_addr_hold: got %h want 07fe", mem_address); end
        req0 = 1; we0 = 0; addr0 = 16'h07FE;
        tick(); tick();
        n_cmp++; if ({ack0, err0} !== 2'b10 || rdata !== 16'hABCD) begin n_bad++; $display("FAIL rb_read: got ack/err %b rdata %h want 10 abcd", {ack0, err0}, rdata); end
        req0 = 0;
        tick();
    endtask

    // Odd in-range address passes through; 0x07FF is out of range.
    task automatic test_boundaries();
        int wr_cycles = 0;
        req0 = 1; we0 = 0; addr0 = 16'h0009;
        tick(); tick();
        n_cmp++; if ({ack0, err0} !== 2'b10 || rdata !== 16'h105A) begin n_bad++; $display("FAIL odd_read: got ack/err %b rdata %h want 10 105a", {ack0, err0}, rdata); end
        req0 = 0;
        tick();
        req0 = 1; we0 = 1; addr0 = 16'h07FF; wdata0 = 16'h1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (mem_wr_en) wr_cycles++;
            if (k == 1) begin
                n_cmp++; if ({ack0, err0} !== 2'b11 || rdata !== 16'h0) begin n_bad++; $display("FAIL bad_addr_resp: got ack/err %b rdata %h want 11 0000", {ack0, err0}, rdata); end
                req0 = 0; we0 = 0;
            end
        end
        n_cmp++; if (wr_cycles !== 0) begin n_bad++; $display("FAIL bad_addr_wr_en: got %0d want 0", wr_cycles); end
        n_cmp++; if (mem[2047] !== 8'hCD) begin n_bad++; $display("FAIL bad_addr_mem: got %h want cd", mem[2047]); end
    endtask

    // Both requesters held after reset: acks 0,1,0,1 one every 3 cycles.
    task automatic test_round_robin();
        logic e0, e1;
        reset = 1;
        req0 = 1; we0 = 0; addr0 = 16'h0008;
        req1 = 1; we1 = 0; addr1 = 16'h0009;
        tick();
        n_cmp++; if ({busy, ack0, ack1} !== 3'b000) begin n_bad++; $display("FAIL rr_reset_dom: got %b want 000", {busy, ack0, ack1}); end
        reset = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            e0 = (k % 3 == 1) && ((k / 3) % 2 == 0);
            e1 = (k % 3 == 1) && ((k / 3) % 2 == 1);
            n_cmp++; if ({ack0, ack1} !== {e0, e1}) begin n_bad++; $display("FAIL rr_ack k=%0d: got %b want %b", k, {ack0, ack1}, {e0, e1}); end
        end
        idle_inputs();
        tick();
    endtask

    // Lone req1 wins with pointer at 0 and leaves the pointer on 0, so a tie goes to req0.
    task automatic test_single_then_both();
        reset = 1; tick(); reset = 0;
        req1 = 1; addr1 = 16'h0008;
        tick(); tick();
        n_cmp++; if ({ack0, ack1} !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b want 01", {ack0, ack1}); end
        req0 = 1; addr0 = 16'h0008;
        tick(); tick(); tick();
        n_cmp++; if ({ack0, ack1} !== 2'b10) begin n_bad++; $display("FAIL tie_after_single: got %b want 10", {ack0, ack1}); end
        idle_inputs();
        tick();
    endtask

    // Reset during ACCESS of a write aborts it without an ack.
    task automatic test_reset_abort();
        int acks = 0;
        req0 = 1; we0 = 1; addr0 = 16'h0100; wdata0 = 16'h1234;
        tick();
        n_cmp++; if (mem_wr_en !== 1'b1) begin n_bad++; $display("FAIL abort_pre_wr_en: got %b want 1", mem_wr_en); end
        reset = 1; idle_inputs();
        tick();
        n_cmp++; if ({busy, mem_wr_en, ack0} !== 3'b000) begin n_bad++; $display("FAIL abort_state: got %b want 000", {busy, mem_wr_en, ack0}); end
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ack0 || ack1) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL abort_no_ack: got %0d want 0", acks); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[8] = 8'h00; mem[9] = 8'h10; mem[10] = 8'h5A;
        reset = 1;
        idle_inputs();
        test_reset();
        test_read();
        test_write_read();
        test_boundaries();
        test_round_robin();
        test_single_then_both();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
